parse_replay_sched: RTL and testbench

//  Replays buffered flows (PKTS_PER_FLOW packets x BEATS_PER_PKT beats of 64b) from the parse data/len FIFOs and routes them.

---
 rtl/pre_parse_pkg.sv | 35 +++
 rtl/sched_desc_fifo.sv | 57 +++++
 rtl/parse_replay_sched.sv | 216 +++++++++++++++++++++
 tb/tb_parse_replay_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pre_parse_pkg.sv
// Shared definitions for the parse replay scheduler.
// Holds flow type codes, geometry constants, the descriptor layout,
// the scheduler state encoding and the per-packet routing decision.
package pre_parse_pkg;

  localparam logic [2:0] FLOW_TYPE_ENTROPY = 3'b000;
  localparam logic [2:0] FLOW_TYPE_SNI     = 3'b001;

  localparam int BEATS_PER_PKT = 33;
  localparam int PKTS_PER_FLOW = 5;
  localparam int DESC_DEPTH    = 8;
  localparam int CREDIT_W      = 6;
  localparam int DESC_W        = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PKT_WAIT,
    S_PKT_RD,
    S_FLOW_END
  } sched_state_t;

  typedef enum logic [1:0] {
    ROUTE_DRAIN,
    ROUTE_ENT,
    ROUTE_PM
  } route_t;

  typedef struct packed {
    logic [7:0] flow_id;
    logic [2:0] flow_type;
    logic [2:0] which_pkt;
  } desc_t;

endpackage

// File: rtl/sched_desc_fifo.sv
// Synchronous descriptor FIFO with full/empty flags.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_din  : write request and data
//   i_pop          : read request (head is shown on o_dout combinationally)
//   o_dout         : head entry
//   o_full/o_empty : occupancy flags
//   o_drop         : push refused because the FIFO is full and not popping
import pre_parse_pkg::*;

module sched_desc_fifo #(
  parameter int WIDTH = DESC_W,
  parameter int DEPTH = DESC_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  // Extra pointer bit distinguishes full from empty.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/parse_replay_sched.sv
// Replays buffered flows from the parse data/length FIFOs and routes each
// packet to the entropy engine, the pattern-match engine, or drains it.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_desc_*, o_desc_ready         : classifier descriptor push interface
//   i_pkt_wr_done                  : one complete packet landed in the data FIFO
//   o_buf_rd_en/i_buf_data         : data FIFO read (1-cycle latency)
//   o_len_rd_en/i_len_data         : length FIFO read (1-cycle latency)
//   i_ent_ready, i_pm_ready        : engine packet-boundary flow control
//   o_data, o_ent_valid, o_pm_valid: beat stream to the engines
//   o_pkt_len/o_pkt_num/o_beat_cnt : per-beat packet metadata
//   o_flow_id/o_flow_type          : current flow
//   o_flow_start/o_flow_done       : flow boundary pulses
//   o_err                          : sticky {credit overflow, descriptor dropped}
import pre_parse_pkg::*;

module parse_replay_sched (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_desc_valid,
  input  logic [7:0]  i_desc_flow_id,
  input  logic [2:0]  i_desc_flow_type,
  input  logic [2:0]  i_desc_which_pkt,
  output logic        o_desc_ready,
  input  logic        i_pkt_wr_done,
  output logic        o_buf_rd_en,
  input  logic [63:0] i_buf_data,
  output logic        o_len_rd_en,
  input  logic [7:0]  i_len_data,
  input  logic        i_ent_ready,
  input  logic        i_pm_ready,
  output logic [63:0] o_data,
  output logic        o_ent_valid,
  output logic        o_pm_valid,
  output logic [7:0]  o_pkt_len,
  output logic [2:0]  o_pkt_num,
  output logic [5:0]  o_beat_cnt,
  output logic [7:0]  o_flow_id,
  output logic [2:0]  o_flow_type,
  output logic        o_flow_start,
  output logic        o_flow_done,
  output logic [1:0]  o_err
);
  sched_state_t        r_state, w_state_next;
  logic [CREDIT_W-1:0] r_credit;
  logic [2:0]          r_pkt_num;
  logic [5:0]          r_beat;
  logic [7:0]          r_flow_id;
  logic [2:0]          r_flow_type;
  logic [2:0]          r_which_pkt;
  route_t              r_route, w_route;
  logic [1:0]          r_err;

  logic        r_s1_rd, r_s1_len, r_s1_ent, r_s1_pm;
  logic [5:0]  r_s1_beat;
  logic [2:0]  r_s1_pkt;
  logic [63:0] r_data;
  logic        r_ent_valid, r_pm_valid;
  logic [7:0]  r_pkt_len;
  logic [2:0]  r_out_pkt;
  logic [5:0]  r_out_beat;

  logic [DESC_W-1:0] w_fifo_dout;
  desc_t             w_desc;
  logic w_fifo_full, w_fifo_empty, w_drop, w_pop;
  logic w_target_ready, w_go, w_last_beat, w_last_pkt;

  sched_desc_fifo #(.WIDTH(DESC_W), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_desc_valid),
    .i_din   ({i_desc_flow_id, i_desc_flow_type, i_desc_which_pkt}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_drop  (w_drop)
  );

  assign w_desc = desc_t'(w_fifo_dout);

  // Only the SNI packet of a type-001 flow reaches the pattern matcher;
  // which_pkt beyond the flow length never matches, so the flow drains.
  always_comb begin
    w_route = ROUTE_DRAIN;
    if (r_flow_type == FLOW_TYPE_ENTROPY)
      w_route = ROUTE_ENT;
    else if (r_flow_type == FLOW_TYPE_SNI && r_which_pkt == r_pkt_num)
      w_route = ROUTE_PM;
  end

  always_comb begin
    case (w_route)
      ROUTE_ENT: w_target_ready = i_ent_ready;
      ROUTE_PM:  w_target_ready = i_pm_ready;
      default:   w_target_ready = 1'b1;
    endcase
  end

  assign w_go        = (r_state == S_PKT_WAIT) && (r_credit != '0) && w_target_ready;
  assign w_last_beat = (r_beat == 6'(BEATS_PER_PKT - 1));
  assign w_last_pkt  = (r_pkt_num == 3'(PKTS_PER_FLOW - 1));

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    o_buf_rd_en  = 1'b0;
    o_len_rd_en  = 1'b0;
    o_flow_start = 1'b0;
    o_flow_done  = 1'b0;
    case (r_state)
      S_IDLE:     if (!w_fifo_empty) w_state_next = S_LOAD;
      S_LOAD: begin
        w_pop        = 1'b1;
        o_flow_start = 1'b1;
        w_state_next = S_PKT_WAIT;
      end
      S_PKT_WAIT: if (w_go) w_state_next = S_PKT_RD;
      S_PKT_RD: begin
        o_buf_rd_en = 1'b1;
        o_len_rd_en = (r_beat == '0);
        if (w_last_beat) w_state_next = w_last_pkt ? S_FLOW_END : S_PKT_WAIT;
      end
      S_FLOW_END: begin
        o_flow_done  = 1'b1;
        w_state_next = S_IDLE;
      end
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_credit    <= '0;
      r_pkt_num   <= '0;
      r_beat      <= '0;
      r_flow_id   <= '0;
      r_flow_type <= '0;
      r_which_pkt <= '0;
      r_route     <= ROUTE_DRAIN;
      r_err       <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_LOAD) begin
        r_flow_id   <= w_desc.flow_id;
        r_flow_type <= w_desc.flow_type;
        r_which_pkt <= w_desc.which_pkt;
        r_pkt_num   <= '0;
      end
      if (w_go) begin
        r_route <= w_route;
        r_beat  <= '0;
      end
      if (r_state == S_PKT_RD) begin
        if (!w_last_beat)     r_beat    <= r_beat + 1'b1;
        else if (!w_last_pkt) r_pkt_num <= r_pkt_num + 1'b1;
      end
      // Simultaneous arrival and consumption cancel out.
      if (i_pkt_wr_done && !w_go) begin
        if (r_credit == '1) r_err[1] <= 1'b1;
        else                r_credit <= r_credit + 1'b1;
      end else if (!i_pkt_wr_done && w_go) begin
        r_credit <= r_credit - 1'b1;
      end
      if (w_drop) r_err[0] <= 1'b1;
    end
  end

  // Stage 1 tracks the read issued this cycle; stage 2 meets the FIFO data
  // that arrives one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_rd     <= 1'b0;
      r_s1_len    <= 1'b0;
      r_s1_ent    <= 1'b0;
      r_s1_pm     <= 1'b0;
      r_s1_beat   <= '0;
      r_s1_pkt    <= '0;
      r_data      <= '0;
      r_ent_valid <= 1'b0;
      r_pm_valid  <= 1'b0;
      r_pkt_len   <= '0;
      r_out_pkt   <= '0;
      r_out_beat  <= '0;
    end else begin
      r_s1_rd     <= o_buf_rd_en;
      r_s1_len    <= o_len_rd_en;
      r_s1_ent    <= o_buf_rd_en && (r_route == ROUTE_ENT);
      r_s1_pm     <= o_buf_rd_en && (r_route == ROUTE_PM);
      r_s1_beat   <= r_beat;
      r_s1_pkt    <= r_pkt_num;
      r_ent_valid <= r_s1_ent;
      r_pm_valid  <= r_s1_pm;
      if (r_s1_rd) begin
        r_data     <= i_buf_data;
        r_out_beat <= r_s1_beat;
        r_out_pkt  <= r_s1_pkt;
      end
      if (r_s1_len) r_pkt_len <= i_len_data;
    end
  end

  // Gated with reset so every output reads 0 while reset is held.
  assign o_desc_ready = i_rst_n && !w_fifo_full;
  assign o_data       = r_data;
  assign o_ent_valid  = r_ent_valid;
  assign o_pm_valid   = r_pm_valid;
  assign o_pkt_len    = r_pkt_len;
  assign o_pkt_num    = r_out_pkt;
  assign o_beat_cnt   = r_out_beat;
  assign o_flow_id    = r_flow_id;
  assign o_flow_type  = r_flow_type;
  assign o_err        = r_err;

endmodule

// File: tb/tb_parse_replay_sched.sv
`timescale 1ns/1ps
module tb_parse_replay_sched;
  import pre_parse_pkg::*;

  logic        clk;
  logic        i_rst_n;
  logic        i_desc_valid;
  logic [7:0]  i_desc_flow_id;
  logic [2:0]  i_desc_flow_type;
  logic [2:0]  i_desc_which_pkt;
  logic        o_desc_ready;
  logic        i_pkt_wr_done;
  logic        o_buf_rd_en;
  logic [63:0] i_buf_data;
  logic        o_len_rd_en;
  logic [7:0]  i_len_data;
  logic        i_ent_ready;
  logic        i_pm_ready;
  logic [63:0] o_data;
  logic        o_ent_valid;
  logic        o_pm_valid;
  logic [7:0]  o_pkt_len;
  logic [2:0]  o_pkt_num;
  logic [5:0]  o_beat_cnt;
  logic [7:0]  o_flow_id;
  logic [2:0]  o_flow_type;
  logic        o_flow_start;
  logic        o_flow_done;
  logic [1:0]  o_err;

  parse_replay_sched dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_desc_valid(i_desc_valid), .i_desc_flow_id(i_desc_flow_id),
    .i_desc_flow_type(i_desc_flow_type), .i_desc_which_pkt(i_desc_which_pkt),
    .o_desc_ready(o_desc_ready), .i_pkt_wr_done(i_pkt_wr_done),
    .o_buf_rd_en(o_buf_rd_en), .i_buf_data(i_buf_data),
    .o_len_rd_en(o_len_rd_en), .i_len_data(i_len_data),
    .i_ent_ready(i_ent_ready), .i_pm_ready(i_pm_ready),
    .o_data(o_data), .o_ent_valid(o_ent_valid), .o_pm_valid(o_pm_valid),
    .o_pkt_len(o_pkt_len), .o_pkt_num(o_pkt_num), .o_beat_cnt(o_beat_cnt),
    .o_flow_id(o_flow_id), .o_flow_type(o_flow_type),
    .o_flow_start(o_flow_start), .o_flow_done(o_flow_done), .o_err(o_err)
  );

  logic [36:0] ctl_outs;
  assign ctl_outs = {o_buf_rd_en, o_len_rd_en, o_ent_valid, o_pm_valid, o_pkt_len,
                     o_pkt_num, o_beat_cnt, o_flow_id, o_flow_type, o_flow_start,
                     o_flow_done, o_err, o_desc_ready};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: routing decided per packet from the descriptor rules.
  typedef struct {
    int         route;   // 1 = entropy, 2 = pattern match
    logic [63:0] data;
    int         pkt;
    int         beat;
    logic [7:0] len;
  } exp_beat_t;

  exp_beat_t   exp_q[$];
  int          route_q[$];
  logic [63:0] data_q[$];
  logic [7:0]  len_q[$];
  logic [10:0] exp_desc_q[$];
  int          pkt_ctr = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          rd_cnt = 0, ent_cnt = 0, pm_cnt = 0, done_cnt = 0, start_cnt = 0;
  bit          jitter = 0;

  function automatic int route_of(input logic [2:0] ftype, input logic [2:0] which, input int p);
    if (ftype == 3'b000) return 1;
    if (ftype == 3'b001 && int'(which) == p) return 2;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (jitter) begin
      i_ent_ready = 1'($urandom);
      i_pm_ready  = 1'($urandom);
    end
  endtask

  task automatic push_desc(input logic [7:0] id, input logic [2:0] ftype,
                           input logic [2:0] which, input bit accepted);
    i_desc_valid     = 1'b1;
    i_desc_flow_id   = id;
    i_desc_flow_type = ftype;
    i_desc_which_pkt = which;
    tick();
    i_desc_valid = 1'b0;
    if (accepted) begin
      exp_desc_q.push_back({id, ftype});
      for (int p = 0; p < 5; p++) route_q.push_back(route_of(ftype, which, p));
    end
  endtask

  // Write one packet into the modelled data/len FIFOs, optionally signalling it.
  task automatic add_pkt(input bit pulse);
    int r;
    int p;
    logic [7:0]  len;
    logic [63:0] w;
    r = (route_q.size() > 0) ? route_q.pop_front() : 0;
    p = pkt_ctr % 5;
    pkt_ctr++;
    len = 8'($urandom);
    len_q.push_back(len);
    for (int b = 0; b < 33; b++) begin
      w = {$urandom, $urandom};
      data_q.push_back(w);
      if (r != 0) exp_q.push_back('{r, w, p, b, len});
    end
    if (pulse) begin
      i_pkt_wr_done = 1'b1;
      tick();
      i_pkt_wr_done = 1'b0;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("flow_done_within_budget", 64'(done_cnt >= target), 64'd1);
  endtask

  // Data/length FIFO responders with one-cycle read latency.
  initial begin
    bit rd, lrd;
    i_buf_data = '0;
    i_len_data = '0;
    forever begin
      @(negedge clk);
      rd  = o_buf_rd_en;
      lrd = o_len_rd_en;
      @(posedge clk);
      #1;
      if (rd)  i_buf_data = (data_q.size() > 0) ? data_q.pop_front() : 64'd0;
      if (lrd) i_len_data = (len_q.size() > 0) ? len_q.pop_front() : 8'd0;
    end
  end

  // Output monitor / scoreboard.
  initial begin
    bit prev_start = 0;
    exp_beat_t e;
    logic [10:0] d;
    forever begin
      @(negedge clk);
      if (o_buf_rd_en) rd_cnt++;
      if (o_flow_done) done_cnt++;
      if (prev_start) begin
        if (exp_desc_q.size() == 0) check("unexpected_flow", 64'd1, 64'd0);
        else begin
          d = exp_desc_q.pop_front();
          check("flow_id", 64'(o_flow_id), 64'(d[10:3]));
          check("flow_type", 64'(o_flow_type), 64'(d[2:0]));
        end
      end
      prev_start = o_flow_start;
      if (o_flow_start) start_cnt++;
      if (o_ent_valid || o_pm_valid) begin
        if (o_ent_valid) ent_cnt++;
        if (o_pm_valid)  pm_cnt++;
        if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("valid_route", 64'({o_pm_valid, o_ent_valid}),
                (e.route == 1) ? 64'd1 : 64'd2);
          check("beat_data", o_data, e.data);
          check("beat_cnt", 64'(o_beat_cnt), 64'(e.beat));
          check("pkt_num", 64'(o_pkt_num), 64'(e.pkt));
          check("pkt_len", 64'(o_pkt_len), 64'(e.len));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p0, r0, d0, s0, n, gap;
    logic [2:0] t;
    i_rst_n = 1'b0; i_desc_valid = 1'b0; i_desc_flow_id = '0; i_desc_flow_type = '0;
    i_desc_which_pkt = '0; i_pkt_wr_done = 1'b0; i_ent_ready = 1'b0; i_pm_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl_outputs", 64'(ctl_outs), 64'd0);
    check("reset_data", o_data, 64'd0);
    i_rst_n = 1'b1;
    tick();
    check("desc_ready_after_reset", 64'(o_desc_ready), 64'd1);
    check("err_after_reset", 64'(o_err), 64'd0);

    // Entropy flow id 7.
    i_ent_ready = 1'b1; i_pm_ready = 1'b1;
    e0 = ent_cnt; p0 = pm_cnt; r0 = rd_cnt; d0 = done_cnt; s0 = start_cnt;
    push_desc(8'd7, 3'b000, 3'd0, 1);
    for (int k = 0; k < 5; k++) add_pkt(1);
    wait_done(d0 + 1, 2000);
    repeat (3) tick();
    check("t1_ent_beats", 64'(ent_cnt - e0), 64'd165);
    check("t1_pm_beats", 64'(pm_cnt - p0), 64'd0);
    check("t1_rd_en", 64'(rd_cnt - r0), 64'd165);
    check("t1_flow_done", 64'(done_cnt - d0), 64'd1);
    check("t1_flow_start", 64'(start_cnt - s0), 64'd1);

    // SNI flow, packet 2 to pattern matcher; entropy ready is irrelevant.
    i_ent_ready = 1'b0;
    e0 = ent_cnt; p0 = pm_cnt; r0 = rd_cnt; d0 = done_cnt;
    push_desc(8'($urandom), 3'b001, 3'd2, 1);
    for (int k = 0; k < 5; k++) add_pkt(1);
    wait_done(d0 + 1, 2000);
    repeat (3) tick();
    check("t2_pm_beats", 64'(pm_cnt - p0), 64'd33);
    check("t2_ent_beats", 64'(ent_cnt - e0), 64'd0);
    check("t2_rd_en", 64'(rd_cnt - r0), 64'd165);

    // Entropy stall at packet boundary; leftover credit must be zero.
    i_ent_ready = 1'b1;
    e0 = ent_cnt; r0 = rd_cnt; d0 = done_cnt;
    push_desc(8'($urandom), 3'b000, 3'd0, 1);
    repeat (10) tick();
    check("t3_no_read_without_credit", 64'(rd_cnt - r0), 64'd0);
    add_pkt(1);
    n = 0;
    while (rd_cnt - r0 < 10 && n < 200) begin tick(); n++; end
    i_ent_ready = 1'b0;
    for (int k = 0; k < 4; k++) add_pkt(1);
    n = 0;
    while (rd_cnt - r0 < 33 && n < 200) begin tick(); n++; end
    check("t3_midpkt_ready_drop_no_stall", 64'(rd_cnt - r0), 64'd33);
    repeat (50) tick();
    check("t3_stalled_while_not_ready", 64'(rd_cnt - r0), 64'd33);
    i_ent_ready = 1'b1;
    check("t3_no_rd_same_cycle", 64'(o_buf_rd_en), 64'd0);
    tick();
    check("t3_rd_one_cycle_after_ready", 64'(o_buf_rd_en), 64'd1);
    wait_done(d0 + 1, 2000);
    repeat (3) tick();
    check("t3_ent_beats", 64'(ent_cnt - e0), 64'd165);

    // Random flows with ready jitter.
    jitter = 1;
    r0 = rd_cnt; d0 = done_cnt;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 3);
      t = (n == 0) ? 3'd0 : (n == 1) ? 3'd1 : 3'($urandom_range(0, 7));
      push_desc(8'($urandom), t, 3'($urandom_range(0, 7)), 1);
    end
    for (int k = 0; k < 30; k++) begin
      gap = $urandom_range(0, 5);
      repeat (gap) tick();
      add_pkt(1);
    end
    wait_done(d0 + 6, 20000);
    jitter = 0; i_ent_ready = 1'b1; i_pm_ready = 1'b1;
    repeat (3) tick();
    check("rand_rd_en", 64'(rd_cnt - r0), 64'd990);
    check("rand_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Descriptor FIFO full, drop and push+pop at full.
    d0 = done_cnt;
    push_desc(8'($urandom), 3'b000, 3'd0, 1);
    repeat (3) tick();
    for (int k = 0; k < 8; k++)
      push_desc(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1);
    check("t4_full_ready_low", 64'(o_desc_ready), 64'd0);
    check("t4_no_err_yet", 64'(o_err), 64'd0);
    push_desc(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 0);
    check("t4_drop_err", 64'(o_err), 64'd1);
    for (int k = 0; k < 5; k++) add_pkt(1);
    n = 0;
    while (!o_flow_start && n < 500) begin tick(); n++; end
    check("t4_next_load_seen", 64'(o_flow_start), 64'd1);
    push_desc(8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1);
    check("t4_pushpop_still_full", 64'(o_desc_ready), 64'd0);
    check("t4_pushpop_no_drop", 64'(o_err), 64'd1);
    jitter = 1;
    for (int k = 0; k < 45; k++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      add_pkt(1);
    end
    wait_done(d0 + 10, 30000);
    jitter = 0; i_ent_ready = 1'b1; i_pm_ready = 1'b1;
    repeat (3) tick();
    check("t4_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("t4_all_flows_started", 64'(exp_desc_q.size()), 64'd0);
    check("t4_credit_zero", 64'(dut.r_credit), 64'd0);

    // Credit saturation and coincident increment/decrement.
    i_pkt_wr_done = 1'b1;
    repeat (63) tick();
    i_pkt_wr_done = 1'b0;
    check("t5_credit_63", 64'(dut.r_credit), 64'd63);
    check("t5_no_overflow_yet", 64'(o_err), 64'd1);
    i_pkt_wr_done = 1'b1;
    tick();
    i_pkt_wr_done = 1'b0;
    check("t5_overflow_err", 64'(o_err), 64'd3);
    check("t5_credit_held", 64'(dut.r_credit), 64'd63);
    push_desc(8'($urandom), 3'b000, 3'd0, 1);
    add_pkt(0);
    n = 0;
    while (!o_flow_start && n < 50) begin tick(); n++; end
    tick();
    r0 = rd_cnt;
    i_pkt_wr_done = 1'b1;
    tick();
    i_pkt_wr_done = 1'b0;
    check("t5_pkt_started", 64'(o_buf_rd_en), 64'd1);
    check("t5_credit_unchanged", 64'(dut.r_credit), 64'd63);

    // Reset in the middle of a packet read.
    n = 0;
    while (rd_cnt - r0 < 15 && n < 100) begin tick(); n++; end
    check("t6_at_beat15", 64'(rd_cnt - r0), 64'd15);
    i_rst_n = 1'b0;
    #1;
    check("t6_reset_ctl_outputs", 64'(ctl_outs), 64'd0);
    check("t6_reset_data", o_data, 64'd0);
    repeat (2) @(posedge clk);
    #3;
    exp_q.delete(); route_q.delete(); data_q.delete(); len_q.delete(); exp_desc_q.delete();
    pkt_ctr = 0;
    i_rst_n = 1'b1;
    tick();
    check("t6_state_idle", 64'(dut.r_state), 64'(S_IDLE));
    check("t6_desc_ready", 64'(o_desc_ready), 64'd1);
    check("t6_err_cleared", 64'(o_err), 64'd0);
    e0 = ent_cnt; p0 = pm_cnt; r0 = rd_cnt; d0 = done_cnt;
    push_desc(8'h5A, 3'b001, 3'd0, 1);
    for (int k = 0; k < 5; k++) add_pkt(1);
    wait_done(d0 + 1, 2000);
    repeat (3) tick();
    check("t6_restart_pm_beats", 64'(pm_cnt - p0), 64'd33);
    check("t6_restart_ent_beats", 64'(ent_cnt - e0), 64'd0);
    check("t6_restart_rd_en", 64'(rd_cnt - r0), 64'd165);
    check("t6_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
